buraq_rf_wb_arbiter: RTL and testbench
======================================

BURAQ_RF_WB_ARBITER -- requirements
Module: buraq_rf_wb_arbiter

Interface
REQ-001 Parameter DataWidth, default 32, width of writeback data and register-file write data.
REQ-002 Parameter NumSrc, default 3, number of writeback requesters (index 0 ALU, 1 LSU, 2 MDU).
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 wb_valid_i  input  NumSrc  per-source writeback request.
REQ-006 wb_addr_i  input  NumSrc x 5  per-source destination register.
REQ-007 wb_data_i  input  NumSrc x DataWidth  per-source writeback data.
REQ-008 wb_ready_o  output  NumSrc  per-source grant, one-hot or zero.
REQ-009 issue_i  input  1  instruction issued that will write a register.
REQ-010 issue_rd_i  input  5  destination of the issued instruction.
REQ-011 raddr_a_i, raddr_b_i  input  5 each  source operands of the instruction being decoded.
REQ-012 stall_o  output  1  read-after-write hazard on either source operand.
REQ-013 waddr_a_o  output  5  register-file write address.
REQ-014 wdata_a_o  output  DataWidth  register-file write data.
REQ-015 we_a_o  output  1  register-file write enable.
REQ-016 busy_o  output  32  scoreboard pending-write bits; bit 0 always 0.

Function
REQ-017 Handshake: transfer on source i when wb_valid_i[i] and wb_ready_o[i] are both high; the source holds addr/data stable while valid and not ready.
REQ-018 wb_ready_o is combinational from wb_valid_i and the round-robin pointer; at most one bit is high per cycle.
REQ-019 Arbitration is round-robin: search starts at index rr_ptr; after a grant to i, rr_ptr becomes (i+1) mod NumSrc; with no grant, rr_ptr holds.
REQ-020 Write port is registered: a transfer in cycle N drives we_a_o=1, waddr_a_o, wdata_a_o in cycle N+1 (one-cycle latency).
REQ-021 In cycles with no transfer, we_a_o=0, and waddr_a_o and wdata_a_o hold their last values.
REQ-022 A transfer with address 0 is granted and consumed, but we_a_o stays 0 for it.
REQ-023 Scoreboard: busy[r] is set on the cycle after issue_i with issue_rd_i=r, r!=0; issue to r=0 is ignored.
REQ-024 busy[r] is cleared on the cycle after a transfer with address r.
REQ-025 When issue of r and a transfer to r occur in the same cycle, the set wins and busy[r]=1.
REQ-026 Issuing to an already-busy r leaves it busy; a single transfer to r clears it (no outstanding-count tracking; one write in flight per register is guaranteed upstream).
REQ-027 stall_o = busy[raddr_a_i] or busy[raddr_b_i], combinational; register 0 never stalls.
REQ-028 There is no bypass: a register whose transfer occurs in cycle N stalls in cycle N and is free from cycle N+1; the register file holds the data in cycle N+2.

Reset
REQ-029 On rst_ni low, asynchronously: rr_ptr=0, busy=0, we_a_o=0, waddr_a_o=0, wdata_a_o=0.
REQ-030 While in reset, wb_ready_o=0 and stall_o=0.
REQ-031 Requests pending at reset are dropped; each source re-presents them after reset.

Verification
REQ-032 After reset, all three sources are valid every cycle with addresses 1/2/3 -> grants in order 0,1,2,0...; we_a_o writes x1,x2,x3 one cycle after each grant.
REQ-033 Issue with rd=5, then raddr_a_i=5 -> stall_o=1 until the LSU transfer to x5 in cycle N; stall_o=0 from cycle N+1; we_a_o=1, waddr_a_o=5 in cycle N+1.
REQ-034 Issue with rd=7 in the same cycle as an ALU transfer to x7 -> busy_o[7]=1 afterwards; a later transfer to x7 clears it.
REQ-035 MDU transfer to x0 with data 0xDEADBEEF -> wb_ready_o[2]=1, we_a_o stays 0, busy_o[0]=0.
REQ-036 Only source 1 is valid for 4 cycles -> it is granted every cycle and rr_ptr alternates 2/2; drop source 1 and raise source 0 and source 2 -> source 2 is granted first.
REQ-037 Assert rst_ni low with busy_o=0x0000_00A0 and we_a_o=1 -> busy_o=0, we_a_o=0 and wb_ready_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/buraq_rf_wb_arbiter.sv
// rtl/buraq_rf_wb_arbiter.sv - round-robin writeback arbiter with register-file write port and RAW scoreboard
module buraq_rf_wb_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumSrc    = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumSrc-1:0]                   wb_valid_i,
  input  logic [NumSrc-1:0][4:0]              wb_addr_i,
  input  logic [NumSrc-1:0][DataWidth-1:0]    wb_data_i,
  output logic [NumSrc-1:0]                   wb_ready_o,
  input  logic                                issue_i,
  input  logic [4:0]                          issue_rd_i,
  input  logic [4:0]                          raddr_a_i,
  input  logic [4:0]                          raddr_b_i,
  output logic                                stall_o,
  output logic [4:0]                          waddr_a_o,
  output logic [DataWidth-1:0]                wdata_a_o,
  output logic                                we_a_o,
  output logic [31:0]                         busy_o
);

  localparam int PtrW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NumSrc-1:0]    grant;
  logic [PtrW-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [PtrW:0]        sum;
  logic [PtrW-1:0]      idx;
  logic [4:0]           gnt_addr;
  logic [DataWidth-1:0] gnt_data;
  logic [31:0]          busy_q, busy_d;

  // Search from rr_ptr upward (wrapping); the first valid source wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NumSrc; k++) begin
      sum = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(NumSrc)) sum = sum - (PtrW+1)'(NumSrc);
      idx = sum[PtrW-1:0];
      if (!gnt_any && rst_ni && wb_valid_i[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = idx;
        gnt_any    = 1'b1;
      end
    end
  end

  assign wb_ready_o = grant;
  assign gnt_addr   = wb_addr_i[gnt_idx];
  assign gnt_data   = wb_data_i[gnt_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PtrW'(NumSrc - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Clear on writeback first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (gnt_any) busy_d[gnt_addr] = 1'b0;
    if (issue_i) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      we_a_o   <= 1'b0;
      if (gnt_any && gnt_addr != 5'd0) begin
        we_a_o    <= 1'b1;
        waddr_a_o <= gnt_addr;
        wdata_a_o <= gnt_data;
      end
    end
  end

  assign busy_o  = busy_q;
  assign stall_o = rst_ni & (busy_q[raddr_a_i] | busy_q[raddr_b_i]);

endmodule

// File: tb/tb_buraq_rf_wb_arbiter.sv
// tb/tb_buraq_rf_wb_arbiter.sv - scoreboard bench for buraq_rf_wb_arbiter
module tb_buraq_rf_wb_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [2:0]            wb_valid = '0;
  logic [2:0][4:0]       wb_addr = '0;
  logic [2:0][31:0]      wb_data = '0;
  logic [2:0]            wb_ready;
  logic                  issue = 1'b0;
  logic [4:0]            issue_rd = '0;
  logic [4:0]            raddr_a = '0;
  logic [4:0]            raddr_b = '0;
  logic                  stall;
  logic [4:0]            waddr_a;
  logic [31:0]           wdata_a;
  logic                  we_a;
  logic [31:0]           busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_rr = 0;
  logic [31:0] m_busy = '0;
  logic [36:0] wq[$];
  logic [2:0]  last_ready;
  logic        last_stall;
  int          g;

  buraq_rf_wb_arbiter #(.DataWidth(32), .NumSrc(3)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .wb_ready_o (wb_ready),
    .issue_i    (issue),
    .issue_rd_i (issue_rd),
    .raddr_a_i  (raddr_a),
    .raddr_b_i  (raddr_b),
    .stall_o    (stall),
    .waddr_a_o  (waddr_a),
    .wdata_a_o  (wdata_a),
    .we_a_o     (we_a),
    .busy_o     (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int i;
    i = m_rr;
    repeat (3) begin
      if (wb_valid[i]) return i;
      i = (i == 2) ? 0 : i + 1;
    end
    return -1;
  endfunction

  // One clock cycle: called just after a negedge with inputs already driven.
  task automatic step(output int gs);
    logic [36:0] e;
    logic [31:0] nb;
    #1;
    gs = model_grant();
    check_eq("wb_ready", wb_ready, (gs < 0) ? 64'd0 : (64'd1 << gs));
    check_eq("stall", stall, m_busy[raddr_a] | m_busy[raddr_b]);
    last_ready = wb_ready;
    last_stall = stall;
    @(posedge clk_i);
    nb = m_busy;
    if (gs >= 0) begin
      if (wb_addr[gs] != 5'd0) wq.push_back({wb_addr[gs], wb_data[gs]});
      nb[wb_addr[gs]] = 1'b0;
      m_rr = (gs + 1) % 3;
    end
    if (issue && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
    m_busy = nb;
    #1;
    if (wq.size() > 0) begin
      e = wq.pop_front();
      check_eq("we_a", we_a, 1);
      check_eq("waddr_a", waddr_a, e[36:32]);
      check_eq("wdata_a", wdata_a, e[31:0]);
    end else begin
      check_eq("we_a_idle", we_a, 0);
    end
    check_eq("busy", busy, m_busy);
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all sources requesting.
    wb_valid = 3'b111;
    wb_addr[0] = 5'd1; wb_addr[1] = 5'd2; wb_addr[2] = 5'd3;
    wb_data[0] = 32'h1111_0001; wb_data[1] = 32'h2222_0002; wb_data[2] = 32'h3333_0003;
    raddr_a = 5'd1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_ready", wb_ready, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", we_a, 0);
    check_eq("rst_waddr", waddr_a, 0);
    check_eq("rst_wdata", wdata_a, 0);
    rst_ni = 1'b1;

    // All three valid: grants rotate 0,1,2.
    for (int c = 0; c < 6; c++) begin
      step(g);
      check_eq("rr_order", last_ready, 3'b001 << (c % 3));
      if (g >= 0) wb_data[g] = $urandom;
    end

    // RAW on x5 resolved by an LSU writeback.
    wb_valid = '0; raddr_a = 5'd0; raddr_b = 5'd0;
    issue = 1'b1; issue_rd = 5'd5;
    step(g);
    issue = 1'b0; raddr_a = 5'd5;
    step(g);
    check_eq("raw_stall", last_stall, 1);
    step(g);
    wb_valid = 3'b010; wb_addr[1] = 5'd5; wb_data[1] = 32'h5555_0005;
    step(g);
    check_eq("raw_stall_xfer", last_stall, 1);
    wb_valid = '0;
    step(g);
    check_eq("raw_free", last_stall, 0);
    check_eq("raw_busy5", busy[5], 0);

    // Same-cycle issue and writeback on x7: set wins.
    raddr_a = 5'd7;
    wb_valid = 3'b001; wb_addr[0] = 5'd7; wb_data[0] = 32'h7777_0007;
    issue = 1'b1; issue_rd = 5'd7;
    step(g);
    check_eq("set_wins", busy[7], 1);
    wb_valid = '0; issue = 1'b0;
    step(g);
    check_eq("x7_stall", last_stall, 1);
    wb_valid = 3'b001; wb_data[0] = 32'h7777_0017;
    step(g);
    wb_valid = '0;
    step(g);
    check_eq("x7_cleared", busy[7], 0);

    // MDU write to x0 is consumed but never written.
    wb_valid = 3'b100; wb_addr[2] = 5'd0; wb_data[2] = 32'hDEAD_BEEF;
    step(g);
    check_eq("x0_grant", last_ready, 3'b100);
    wb_valid = '0;
    step(g);
    check_eq("x0_busy0", busy[0], 0);

    // Lone LSU, then ALU+MDU: pointer sits at 2 so MDU goes first.
    wb_valid = 3'b010; wb_addr[1] = 5'd9;
    for (int c = 0; c < 4; c++) begin
      wb_data[1] = 32'h9900_0000 + c;
      step(g);
      check_eq("lsu_only", last_ready, 3'b010);
    end
    wb_valid = 3'b101; wb_addr[0] = 5'd10; wb_addr[2] = 5'd11;
    wb_data[0] = 32'hA0A0_000A; wb_data[2] = 32'hB0B0_000B;
    step(g);
    check_eq("mdu_first", last_ready, 3'b100);
    wb_valid = 3'b001;
    step(g);
    check_eq("alu_next", last_ready, 3'b001);
    wb_valid = '0;

    // Random traffic; sources hold requests until granted.
    for (int c = 0; c < 60; c++) begin
      issue = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 31));
      raddr_a = 5'($urandom_range(0, 31));
      raddr_b = 5'($urandom_range(0, 31));
      step(g);
      if (g >= 0) wb_valid[g] = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (!wb_valid[s] && $urandom_range(0, 1) == 1) begin
          wb_valid[s] = 1'b1;
          wb_addr[s] = 5'($urandom_range(0, 31));
          wb_data[s] = $urandom;
        end
      end
    end

    // Build busy = 0xA0 with a write in flight, then reset asynchronously.
    wb_valid = '0; issue = 1'b0;
    step(g);
    m_busy = busy;
    issue = 1'b1; issue_rd = 5'd5;
    step(g);
    issue_rd = 5'd7;
    wb_valid = 3'b001; wb_addr[0] = 5'd3; wb_data[0] = 32'h0000_0333;
    step(g);
    issue = 1'b0;
    check_eq("pre_rst_busy", busy & 32'h0000_00A0, 32'h0000_00A0);
    check_eq("pre_rst_we", we_a, 1);
    wb_valid = 3'b111; raddr_a = 5'd5;
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("async_busy", busy, 0);
    check_eq("async_we", we_a, 0);
    check_eq("async_ready", wb_ready, 0);
    check_eq("async_stall", stall, 0);
    check_eq("async_waddr", waddr_a, 0);
    m_busy = '0; m_rr = 0; wq.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(g);
    check_eq("post_rst_grant", last_ready, 3'b001);
    wb_valid = '0;
    step(g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
